eth_tx_arbiter: RTL



---
 rtl/eth_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/eth_tx_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet RMII transmit path.
// The state enum and line constants are reused by the RX/MDIO schedulers.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        IFG      = 2'd3
    } tx_state_t;

    localparam logic [1:0] PREAMBLE_DIBIT     = 2'b01;
    localparam logic [1:0] SFD_DIBIT          = 2'b11;
    localparam int         PRE_DIBITS_DEFAULT = 32;
    localparam int         IFG_CYCLES_DEFAULT = 48;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after ptr_i
// (modulo N) wins; ptr_i itself has the lowest priority.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          any_o,
    output logic [PW-1:0] idx_o,
    output logic [N-1:0]  gnt_o
);

    int best_off;

    always_comb begin
        any_o    = 1'b0;
        idx_o    = ptr_i;
        gnt_o    = '0;
        best_off = N;
        // Offset 0 is the slot right after the pointer, i.e. the highest priority.
        for (int j = 0; j < N; j++) begin
            if (req_i[j] && (((j - int'(ptr_i) - 1 + 2 * N) % N) < best_off)) begin
                best_off = (j - int'(ptr_i) - 1 + 2 * N) % N;
                any_o    = 1'b1;
                idx_o    = PW'(j);
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-level round-robin sharing of one RMII TX path: preamble/SFD insertion,
// one-cycle dibit forwarding from the granted source, and inter-frame gap.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | sample requests, pick next owner after rr_ptr
// PREAMBLE | emit PRE_DIBITS-1 preamble dibits then the SFD dibit
// DATA     | forward the owner's dibits; stop on last or abort on underrun
// IFG      | grant released, line quiet for IFG_CYCLES cycles
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int IFG_CYCLES = IFG_CYCLES_DEFAULT,
    parameter int PRE_DIBITS = PRE_DIBITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 eth_txen,
    output logic [1:0]           eth_txd,
    output logic                 underrun
);

    localparam int              PW       = $clog2(NUM_REQ);
    localparam int              CW       = $clog2(max2(PRE_DIBITS, IFG_CYCLES) + 1);
    localparam logic [CW-1:0]   PRE_LAST = CW'(PRE_DIBITS - 1);
    localparam logic [CW-1:0]   IFG_LAST = CW'(IFG_CYCLES - 1);
    localparam logic [PW-1:0]   PTR_RST  = PW'(NUM_REQ - 1);

    tx_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [PW-1:0]        rr_ptr_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 txen_q;
    logic [1:0]           txd_q;
    logic                 underrun_q;

    logic                 arb_any;
    logic [PW-1:0]        arb_idx;
    logic [NUM_REQ-1:0]   arb_gnt;

    logic                 own_valid;
    logic                 own_last;
    logic [1:0]           own_data;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .any_o (arb_any),
        .idx_o (arb_idx),
        .gnt_o (arb_gnt)
    );

    // rr_ptr_q holds the owner's index for the whole frame.
    assign own_valid = req_valid[rr_ptr_q];
    assign own_last  = req_last[rr_ptr_q];
    assign own_data  = req_data[{rr_ptr_q, 1'b0} +: 2];

    assign req_ready = (state_q == DATA) ? grant_q : '0;
    assign grant     = grant_q;
    assign eth_txen  = txen_q;
    assign eth_txd   = txd_q;
    assign underrun  = underrun_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= PTR_RST;
            grant_q    <= '0;
            txen_q     <= 1'b0;
            txd_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    txen_q <= 1'b0;
                    txd_q  <= '0;
                    cnt_q  <= '0;
                    if (arb_any) begin
                        grant_q  <= arb_gnt;
                        rr_ptr_q <= arb_idx;
                        state_q  <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    txen_q <= 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        txd_q   <= SFD_DIBIT;
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        txd_q <= PREAMBLE_DIBIT;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (own_valid) begin
                        txen_q <= 1'b1;
                        txd_q  <= own_data;
                        if (own_last) begin
                            grant_q <= '0;
                            state_q <= IFG;
                        end
                    end else begin
                        // Owner starved the line: abort, the rest of its frame is dropped.
                        txen_q     <= 1'b0;
                        txd_q      <= '0;
                        underrun_q <= 1'b1;
                        grant_q    <= '0;
                        state_q    <= IFG;
                    end
                end
                IFG: begin
                    txen_q <= 1'b0;
                    txd_q  <= '0;
                    if (cnt_q == IFG_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    txen_q  <= 1'b0;
                    txd_q   <= '0;
                end
            endcase
        end
    end

endmodule
